// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding and the
// end-of-program marker that terminates a program load.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Sliced down to the instruction width where it is used.
  localparam logic [63:0] END_MARKER = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/fetch_sequencer_word_assembler.sv
// Packs four valid bytes, MSB first, into one instruction word and
// pulses word_valid_o for one cycle when the word is complete.
module word_assembler #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_i,
  output logic [SIZE-1:0] word_o,
  output logic            word_valid_o
);

  logic [1:0]      cnt_q, cnt_d;
  logic [SIZE-1:0] shift_q, shift_d;
  logic [SIZE-1:0] word_q, word_d;
  logic            valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[SIZE-9:0], byte_i};
      if (cnt_q == 2'd3) begin
        cnt_d   = 2'd0;
        word_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program loader and run/step controller that gates the fetch stage.
//
//   state | meaning
//   IDLE  | stalled, waiting for load/run/step
//   LOAD  | receiving bytes, writing instruction words
//   RUN   | fetch free-running until PC passes program end
//   STEP  | fetch released for exactly one cycle
//   DONE  | program finished, waiting for a new load
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         i_rx_data,
  input  logic                               i_rx_valid,
  input  logic                               i_cmd_load,
  input  logic                               i_cmd_run,
  input  logic                               i_cmd_step,
  input  logic                               i_cmd_halt,
  input  logic [SIZE-1:0]                    i_pc,
  output logic                               o_stall,
  output logic                               o_imem_we,
  output logic [$clog2(MAX_INSTRUCTION)-1:0] o_imem_addr,
  output logic [SIZE-1:0]                    o_imem_wdata,
  output logic [$clog2(MAX_INSTRUCTION):0]   o_prog_len,
  output logic [2:0]                         o_state,
  output logic                               o_step_done,
  output logic                               o_done
);

  localparam int AW  = $clog2(MAX_INSTRUCTION);
  localparam int PLW = AW + 1;

  state_e          state_q, state_d;
  logic [PLW-1:0]  prog_len_q, prog_len_d;
  logic            step_done_q, step_done_d;
  logic            asm_clear, asm_byte_valid, asm_word_valid;
  logic [SIZE-1:0] asm_word;
  logic            has_prog, pc_end, is_marker, imem_we;

  assign has_prog  = (prog_len_q != '0);
  assign pc_end    = (i_pc >= SIZE'(prog_len_q));
  assign is_marker = (asm_word == END_MARKER[SIZE-1:0]);

  // Bytes arriving alongside a halt belong to the aborted partial word.
  assign asm_byte_valid = (state_q == ST_LOAD) && i_rx_valid && !i_cmd_halt;

  word_assembler #(.SIZE(SIZE)) u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_byte_valid),
    .byte_i       (i_rx_data),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    prog_len_d  = prog_len_q;
    step_done_d = 1'b0;
    asm_clear   = 1'b0;
    imem_we     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_load) begin
          state_d    = ST_LOAD;
          prog_len_d = '0;
          asm_clear  = 1'b1;
        end else if (i_cmd_run && has_prog) begin
          state_d = ST_RUN;
        end else if (i_cmd_step && has_prog) begin
          state_d = ST_STEP;
        end
      end
      ST_LOAD: begin
        if (i_cmd_halt) begin
          state_d   = ST_IDLE;
          asm_clear = 1'b1;
        end else if (asm_word_valid) begin
          if (is_marker) begin
            state_d = ST_IDLE;
          end else begin
            imem_we    = 1'b1;
            prog_len_d = prog_len_q + PLW'(1);
            if (prog_len_q == PLW'(MAX_INSTRUCTION - 1)) state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        // End of program outranks a simultaneous halt.
        if (pc_end)          state_d = ST_DONE;
        else if (i_cmd_halt) state_d = ST_IDLE;
      end
      ST_STEP: begin
        step_done_d = 1'b1;
        state_d     = pc_end ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (i_cmd_load) begin
          state_d    = ST_LOAD;
          prog_len_d = '0;
          asm_clear  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      prog_len_q  <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_len_q  <= prog_len_d;
      step_done_q <= step_done_d;
    end
  end

  // The word address always equals the count of words already written.
  assign o_imem_we    = imem_we;
  assign o_imem_addr  = prog_len_q[AW-1:0];
  assign o_imem_wdata = asm_word;
  assign o_prog_len   = prog_len_q;
  assign o_state      = state_q;
  assign o_stall      = !((state_q == ST_RUN) || (state_q == ST_STEP));
  assign o_step_done  = step_done_q;
  assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; instruction-memory writes are
// checked by a scoreboard queue drained by an independent monitor.
module tb_fetch_sequencer;

  localparam int SIZE = 32;
  localparam int MAXI = 10;
  localparam int AW   = $clog2(MAXI);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      i_rx_data = '0;
  logic            i_rx_valid = 1'b0;
  logic            i_cmd_load = 1'b0, i_cmd_run = 1'b0, i_cmd_step = 1'b0, i_cmd_halt = 1'b0;
  logic [SIZE-1:0] i_pc = '0;
  logic            o_stall, o_imem_we, o_step_done, o_done;
  logic [AW-1:0]   o_imem_addr;
  logic [SIZE-1:0] o_imem_wdata;
  logic [AW:0]     o_prog_len;
  logic [2:0]      o_state;

  fetch_sequencer #(.SIZE(SIZE), .MAX_INSTRUCTION(MAXI)) dut (
    .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_cmd_load(i_cmd_load), .i_cmd_run(i_cmd_run), .i_cmd_step(i_cmd_step),
    .i_cmd_halt(i_cmd_halt), .i_pc(i_pc), .o_stall(o_stall),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_prog_len(o_prog_len), .o_state(o_state), .o_step_done(o_step_done),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [SIZE-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_STEP = 3'd3, S_DONE = 3'd4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && o_imem_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", o_imem_addr, o_imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (o_imem_addr !== e.addr || o_imem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL imem_write: got addr %0d data %h, expected addr %0d data %h",
                   o_imem_addr, o_imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  // Four bytes MSB first, then one non-valid cycle carrying garbage data.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    i_rx_data = 8'hA5;
    tick();
  endtask

  task automatic expect_write(input int addr, input logic [31:0] data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pulse_load();
    i_cmd_load = 1'b1; tick(); i_cmd_load = 1'b0;
  endtask
  task automatic pulse_run();
    i_cmd_run = 1'b1; tick(); i_cmd_run = 1'b0;
  endtask
  task automatic pulse_step();
    i_cmd_step = 1'b1; tick(); i_cmd_step = 1'b0;
  endtask
  task automatic pulse_halt();
    i_cmd_halt = 1'b1; tick(); i_cmd_halt = 1'b0;
  endtask

  task automatic load_three();
    pulse_load();
    expect_write(0, 32'h3C01_0003);
    expect_write(1, 32'h3C03_0003);
    expect_write(2, 32'h0022_0820);
    send_word(32'h3C01_0003);
    send_word(32'h3C03_0003);
    send_word(32'h0022_0820);
    send_word(32'hFFFF_FFFF);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_state", 32'(o_state), 32'(S_IDLE));
    check("rst_stall", 32'(o_stall), 32'd1);
    check("rst_we", 32'(o_imem_we), 32'd0);
    check("rst_addr", 32'(o_imem_addr), 32'd0);
    check("rst_wdata", o_imem_wdata, 32'd0);
    check("rst_len", 32'(o_prog_len), 32'd0);
    check("rst_step_done", 32'(o_step_done), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Two words then the end marker
    pulse_load();
    check("load_enter", 32'(o_state), 32'(S_LOAD));
    expect_write(0, 32'h3C01_0003);
    expect_write(1, 32'h3C03_0003);
    send_word(32'h3C01_0003);
    send_word(32'h3C03_0003);
    send_word(32'hFFFF_FFFF);
    tick();
    check("marker_state", 32'(o_state), 32'(S_IDLE));
    check("marker_len", 32'(o_prog_len), 32'd2);
    check("marker_pending", 32'(exp_q.size()), 32'd0);

    // Single step with PC inside the program
    load_three();
    check("len3", 32'(o_prog_len), 32'd3);
    i_pc = 32'd1;
    pulse_step();
    check("step_state", 32'(o_state), 32'(S_STEP));
    check("step_stall", 32'(o_stall), 32'd0);
    check("step_sd_early", 32'(o_step_done), 32'd0);
    tick();
    check("step_back_idle", 32'(o_state), 32'(S_IDLE));
    check("step_stall_after", 32'(o_stall), 32'd1);
    check("step_done_pulse", 32'(o_step_done), 32'd1);
    tick();
    check("step_done_clear", 32'(o_step_done), 32'd0);

    // Halt from RUN
    i_pc = 32'd0;
    pulse_run();
    check("run_enter", 32'(o_state), 32'(S_RUN));
    check("run_stall", 32'(o_stall), 32'd0);
    pulse_halt();
    check("halt_state", 32'(o_state), 32'(S_IDLE));
    check("halt_stall", 32'(o_stall), 32'd1);

    // Run to completion with incrementing PC
    pulse_run();
    for (int pc = 0; pc < 3; pc++) begin
      i_pc = 32'(pc);
      check("run_stall_pc", 32'(o_stall), 32'd0);
      tick();
    end
    i_pc = 32'd3;
    check("run_state_pc3", 32'(o_state), 32'(S_RUN));
    tick();
    check("end_state", 32'(o_state), 32'(S_DONE));
    check("end_stall", 32'(o_stall), 32'd1);
    check("end_done", 32'(o_done), 32'd1);
    pulse_run();
    pulse_step();
    check("done_ignores_cmds", 32'(o_state), 32'(S_DONE));
    check("done_held", 32'(o_done), 32'd1);

    // Halt together with end condition: end wins
    load_three();
    check("reload_done_clr", 32'(o_done), 32'd0);
    i_pc = 32'd0;
    pulse_run();
    i_pc = 32'd3;
    pulse_halt();
    check("halt_vs_end", 32'(o_state), 32'(S_DONE));

    // Load and run in the same IDLE cycle: load wins
    load_three();
    i_cmd_load = 1'b1;
    i_cmd_run  = 1'b1;
    tick();
    i_cmd_load = 1'b0;
    i_cmd_run  = 1'b0;
    check("load_vs_run", 32'(o_state), 32'(S_LOAD));
    check("load_clr_len", 32'(o_prog_len), 32'd0);

    // Halt during LOAD discards the partial word
    expect_write(0, 32'h1122_3344);
    send_word(32'h1122_3344);
    send_byte(8'h55);
    send_byte(8'h66);
    pulse_halt();
    check("abort_state", 32'(o_state), 32'(S_IDLE));
    check("abort_len", 32'(o_prog_len), 32'd1);

    // Step with PC already past the end goes to DONE
    i_pc = 32'd5;
    pulse_step();
    tick();
    check("step_to_done", 32'(o_state), 32'(S_DONE));

    // Empty program: run and step ignored
    pulse_load();
    pulse_halt();
    check("empty_len", 32'(o_prog_len), 32'd0);
    i_pc = 32'd0;
    pulse_run();
    check("empty_run", 32'(o_state), 32'(S_IDLE));
    pulse_step();
    check("empty_step", 32'(o_state), 32'(S_IDLE));

    // Twelve words into a ten-word memory
    pulse_load();
    for (int i = 0; i < 12; i++) begin
      if (i < MAXI) expect_write(i, 32'h1000_0000 + 32'(i));
      send_word(32'h1000_0000 + 32'(i));
    end
    check("full_state", 32'(o_state), 32'(S_IDLE));
    check("full_len", 32'(o_prog_len), 32'd10);
    check("full_pending", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a word
    pulse_load();
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b0;
    #1;
    check("mid_rst_state", 32'(o_state), 32'(S_IDLE));
    check("mid_rst_len", 32'(o_prog_len), 32'd0);
    check("mid_rst_we", 32'(o_imem_we), 32'd0);
    tick();
    rst = 1'b1;
    send_byte(8'hBE);
    send_byte(8'hEF);
    tick();
    tick();
    check("post_rst_state", 32'(o_state), 32'(S_IDLE));
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
